clock_period_meter: RTL and testbench

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter.sv | 137 +++++++++++++
 tb/tb_clock_period_meter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// Measures the high time, low time and period of sig_in in clk cycles.
// Results publish one cycle after the closing rising edge and then hold until the next publish.
module clock_period_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W:0]   period
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS_HI, MEAS_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic             sig_m_q, sig_s_q, sig_d_q;
    logic [CNT_W-1:0] wait_q, hi_q, lo_q;
    logic [CNT_W-1:0] high_q, low_q;
    logic [CNT_W:0]   period_q;
    logic             busy_q, valid_q, timeout_q;
    logic             rise, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_m_q <= 1'b0;
            sig_s_q <= 1'b0;
            sig_d_q <= 1'b0;
        end else begin
            sig_m_q <= sig_in;
            sig_s_q <= sig_m_q;
            sig_d_q <= sig_s_q;
        end
    end

    assign rise = sig_s_q & ~sig_d_q;
    assign fall = ~sig_s_q & sig_d_q;

    // The edge cycle itself counts as the first cycle of the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            high_q    <= '0;
            low_q     <= '0;
            period_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (state_q != IDLE && stop) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !stop) begin
                            state_q <= ARM;
                            wait_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (rise) begin
                            state_q <= MEAS_HI;
                            hi_q    <= CNT_ONE;
                        end else if (wait_q == CNT_MAX) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            wait_q <= wait_q + CNT_ONE;
                        end
                    end
                    MEAS_HI: begin
                        if (fall) begin
                            state_q <= MEAS_LO;
                            lo_q    <= CNT_ONE;
                        end else if (hi_q == CNT_MAX) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            hi_q <= hi_q + CNT_ONE;
                        end
                    end
                    MEAS_LO: begin
                        if (rise) begin
                            high_q   <= hi_q;
                            low_q    <= lo_q;
                            period_q <= {1'b0, hi_q} + {1'b0, lo_q};
                            valid_q  <= 1'b1;
                            if (cont) begin
                                state_q <= MEAS_HI;
                                hi_q    <= CNT_ONE;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else if (lo_q == CNT_MAX) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            lo_q <= lo_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign high_time = high_q;
    assign low_time  = low_q;
    assign period    = period_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter with narrow counters so overflow paths are reachable.
module tb_clock_period_meter;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, sig_in, start, stop, cont;
    logic             busy, valid, timeout;
    logic [CNT_W-1:0] high_time, low_time;
    logic [CNT_W:0]   period;

    typedef struct {
        logic [CNT_W-1:0] hi;
        logic [CNT_W-1:0] lo;
        logic [CNT_W:0]   per;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0, cyc = 0;
    int   vld_cnt = 0, to_cnt = 0, both_cnt = 0;
    int   gen_hi = 3, gen_lo = 3, ph = 0;
    bit   gen_per = 1'b0;

    clock_period_meter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .stop(stop), .cont(cont),
        .busy(busy), .valid(valid), .timeout(timeout),
        .high_time(high_time), .low_time(low_time), .period(period)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_per) begin
                sig_in = (ph < gen_hi);
                ph = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
            end else begin
                sig_in = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (valid === 1'b1) vld_cnt++;
        if (timeout === 1'b1) to_cnt++;
        if (valid === 1'b1 && timeout === 1'b1) both_cnt++;
    end

    task automatic set_pattern(input int h, input int l);
        gen_hi = h; gen_lo = l; ph = 0; gen_per = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    // sel: 0 = valid, 1 = timeout, 2 = busy
    task automatic wait_out(input int sel, input int limit, output bit found, output int at);
        int i;
        found = 1'b0; at = 0; i = 0;
        while (!found && i < limit) begin
            @(negedge clk);
            if ((sel == 0 && valid === 1'b1) || (sel == 1 && timeout === 1'b1) ||
                (sel == 2 && busy === 1'b1)) begin
                found = 1'b1; at = cyc;
            end
            i++;
        end
    endtask

    task automatic wait_sig(input logic level);
        int i;
        i = 0;
        do begin @(negedge clk); i++; end while (sig_in !== level && i < 100);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        total++; if (high_time !== '0) begin bad++; $display("FAIL reset_high: got %0d want 0", high_time); end
        total++; if (low_time !== '0) begin bad++; $display("FAIL reset_low: got %0d want 0", low_time); end
        total++; if (period !== '0) begin bad++; $display("FAIL reset_period: got %0d want 0", period); end
        @(negedge clk) rst_n = 1'b1;
        set_pattern(3, 3);
        repeat (12) @(negedge clk);
        total++; if (busy !== 1'b0 || vld_cnt != 0) begin bad++; $display("FAIL reset_idle: busy=%b valids=%0d want 0/0", busy, vld_cnt); end
    endtask

    task automatic test_single();
        bit f; int at, v0, t0; exp_t e;
        set_pattern(3, 3); cont = 1'b0;
        repeat (4) @(posedge clk);
        v0 = vld_cnt; t0 = to_cnt;
        exp_q.push_back('{4'd3, 4'd3, 5'd6});
        pulse_start();
        wait_out(0, 60, f, at);
        e = exp_q.pop_front();
        total++; if (!f) begin bad++; $display("FAIL single_valid: got none in 60 cycles want one pulse"); end
        total++; if (high_time !== e.hi) begin bad++; $display("FAIL single_high: got %0d want %0d", high_time, e.hi); end
        total++; if (low_time !== e.lo) begin bad++; $display("FAIL single_low: got %0d want %0d", low_time, e.lo); end
        total++; if (period !== e.per) begin bad++; $display("FAIL single_period: got %0d want %0d", period, e.per); end
        repeat (20) @(negedge clk);
        total++; if (vld_cnt - v0 != 1) begin bad++; $display("FAIL single_count: got %0d valids want 1", vld_cnt - v0); end
        total++; if (to_cnt != t0) begin bad++; $display("FAIL single_timeout: got %0d timeouts want 0", to_cnt - t0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic run_timeout(input string name, input bit restart);
        bit f; int b_at, t_at, v0;
        gen_per = 1'b0;
        repeat (5) @(posedge clk);
        v0 = vld_cnt;
        pulse_start();
        wait_out(2, 5, f, b_at);
        total++; if (!f) begin bad++; $display("FAIL %s_busy: busy never rose", name); end
        if (restart) begin
            repeat (6) @(negedge clk);
            pulse_start();
        end
        wait_out(1, 40, f, t_at);
        total++; if (!f) begin bad++; $display("FAIL %s_pulse: no timeout in 40 cycles", name); end
        total++; if (t_at - b_at != 16) begin bad++; $display("FAIL %s_delay: got %0d cycles want 16", name, t_at - b_at); end
        total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_state: valid=%b busy=%b want 0/0", name, valid, busy); end
        total++; if (high_time !== 4'd3 || low_time !== 4'd3 || period !== 5'd6) begin
            bad++; $display("FAIL %s_hold: got %0d/%0d/%0d want 3/3/6", name, high_time, low_time, period);
        end
        repeat (5) @(negedge clk);
        total++; if (vld_cnt != v0) begin bad++; $display("FAIL %s_novalid: got %0d valids want 0", name, vld_cnt - v0); end
    endtask

    task automatic test_stop_lo();
        int v0, t0;
        set_pattern(4, 8); cont = 1'b0;
        wait_sig(1'b1); wait_sig(1'b0);
        v0 = vld_cnt; t0 = to_cnt;
        pulse_start();
        wait_sig(1'b1); wait_sig(1'b0);
        repeat (4) @(negedge clk);
        pulse_stop();
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy: got %b want 0", busy); end
        repeat (30) @(negedge clk);
        total++; if (vld_cnt != v0 || to_cnt != t0) begin
            bad++; $display("FAIL stop_pulses: got %0d valid %0d timeout want 0/0", vld_cnt - v0, to_cnt - t0);
        end
        total++; if (high_time !== 4'd3 || low_time !== 4'd3 || period !== 5'd6) begin
            bad++; $display("FAIL stop_hold: got %0d/%0d/%0d want 3/3/6", high_time, low_time, period);
        end
    endtask

    task automatic test_cont();
        bit f; int at, prev, v0; exp_t e;
        set_pattern(5, 2); cont = 1'b1;
        repeat (3) @(posedge clk);
        v0 = vld_cnt; prev = 0;
        for (int k = 0; k < 3; k++) exp_q.push_back('{4'd5, 4'd2, 5'd7});
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_out(0, 40, f, at);
            e = exp_q.pop_front();
            total++; if (!f) begin bad++; $display("FAIL cont_valid%0d: no valid in 40 cycles", k); end
            total++; if (high_time !== e.hi || low_time !== e.lo || period !== e.per) begin
                bad++; $display("FAIL cont_result%0d: got %0d/%0d/%0d want %0d/%0d/%0d", k,
                                high_time, low_time, period, e.hi, e.lo, e.per);
            end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL cont_busy%0d: got %b want 1", k, busy); end
            if (k > 0) begin
                total++; if (at - prev != 7) begin bad++; $display("FAIL cont_spacing%0d: got %0d want 7", k, at - prev); end
            end
            prev = at;
        end
        pulse_stop();
        cont = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_stop: busy got %b want 0", busy); end
        repeat (20) @(negedge clk);
        total++; if (vld_cnt - v0 != 3) begin bad++; $display("FAIL cont_count: got %0d want 3", vld_cnt - v0); end
    endtask

    task automatic test_boundaries();
        int hs[3] = '{11, 15, 16};
        int ls[3] = '{9, 3, 3};
        bit f; int at, v0; exp_t e;
        cont = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_pattern(hs[k], ls[k]);
            wait_sig(1'b1); wait_sig(1'b0);
            v0 = vld_cnt;
            if (hs[k] < 16) begin
                exp_q.push_back('{CNT_W'(hs[k]), CNT_W'(ls[k]), (CNT_W+1)'(hs[k] + ls[k])});
                pulse_start();
                wait_out(0, 80, f, at);
                e = exp_q.pop_front();
                total++; if (!f || high_time !== e.hi || low_time !== e.lo || period !== e.per) begin
                    bad++; $display("FAIL bound%0d: seen=%0d got %0d/%0d/%0d want %0d/%0d/%0d", k, f,
                                    high_time, low_time, period, e.hi, e.lo, e.per);
                end
            end else begin
                pulse_start();
                wait_out(1, 80, f, at);
                total++; if (!f || vld_cnt != v0) begin
                    bad++; $display("FAIL bound_hi_ovf: timeout seen=%0d valids=%0d want 1/0", f, vld_cnt - v0);
                end
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_start_stop_idle();
        int v0;
        set_pattern(3, 3);
        v0 = vld_cnt;
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL startstop_busy: got %b want 0", busy); end
        repeat (20) @(negedge clk);
        total++; if (busy !== 1'b0 || vld_cnt != v0) begin
            bad++; $display("FAIL startstop_idle: busy=%b valids=%0d want 0/0", busy, vld_cnt - v0);
        end
    endtask

    task automatic test_reset_mid();
        bit f; int at, v1; exp_t e;
        set_pattern(5, 2); cont = 1'b1;
        exp_q.push_back('{4'd5, 4'd2, 5'd7});
        pulse_start();
        wait_out(0, 40, f, at);
        e = exp_q.pop_front();
        total++; if (!f || period !== e.per) begin bad++; $display("FAIL rstmid_pre: seen=%0d period %0d want %0d", f, period, e.per); end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0) begin
            bad++; $display("FAIL rstmid_flags: busy=%b valid=%b timeout=%b want 0", busy, valid, timeout);
        end
        total++; if (high_time !== '0 || low_time !== '0 || period !== '0) begin
            bad++; $display("FAIL rstmid_data: got %0d/%0d/%0d want 0/0/0", high_time, low_time, period);
        end
        cont = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        v1 = vld_cnt;
        repeat (20) @(negedge clk);
        total++; if (busy !== 1'b0 || vld_cnt != v1 || high_time !== '0) begin
            bad++; $display("FAIL rstmid_after: busy=%b valids=%0d high=%0d want 0/0/0", busy, vld_cnt - v1, high_time);
        end
    endtask

    task automatic test_final();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL both_pulses: got %0d cycles want 0", both_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL queue_left: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        run_timeout("timeout", 1'b0);
        run_timeout("startbusy", 1'b1);
        test_stop_lo();
        test_cont();
        test_boundaries();
        test_start_stop_idle();
        test_reset_mid();
        test_final();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
